branch_target_predictor: RTL and testbench

//  Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.

---
 rtl/branch_target_predictor.sv | 146 ++++++++++++++
 tb/tb_branch_target_predictor.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
// Lookup is combinational on the fetch PC; training comes from resolved execute-stage transfers.
module branch_target_predictor #(
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned TAG_W    = 10,
  parameter logic [1:0]  CTR_INIT = 2'b10
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] pc_f_i,
  output logic [31:0] pred_pc_target_f_o,
  output logic        pc_src_pred_f_o,
  output logic        hit_f_o,
  input  logic [31:0] pc_e_i,
  input  logic [31:0] pc_target_e_i,
  input  logic [1:0]  branch_op_e_i,
  input  logic        pc_src_res_e_i,
  input  logic        stall_e_i,
  input  logic        flush_e_i,
  input  logic        invalidate_i
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] pc);
    idx_of = pc[2 +: IDX_W];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] pc);
    tag_of = pc[IDX_W+2 +: TAG_W];
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    sat_inc = (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    sat_dec = (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  logic [ENTRIES-1:0] valid_r;
  logic [1:0]         ctr_r    [ENTRIES];
  logic [TAG_W-1:0]   tag_r    [ENTRIES];
  logic [31:0]        target_r [ENTRIES];

  logic [IDX_W-1:0] idx_f_s;
  logic [IDX_W-1:0] idx_e_s;
  logic [TAG_W-1:0] tag_e_s;
  logic             hit_e_s;
  logic             train_s;
  logic             alloc_s;
  logic             ctr_we_s;
  logic             tgt_we_s;
  logic [1:0]       ctr_next_s;
  logic             unused_pc_bits_s;

  // Address bits outside index/tag deliberately take no part in matching.
  assign unused_pc_bits_s = ^{pc_f_i, pc_e_i};

  assign idx_f_s = idx_of(pc_f_i);
  assign idx_e_s = idx_of(pc_e_i);
  assign tag_e_s = tag_of(pc_e_i);
  assign hit_e_s = valid_r[idx_e_s] && (tag_r[idx_e_s] == tag_e_s);
  assign train_s = (branch_op_e_i != 2'b00) && !stall_e_i && !flush_e_i && !invalidate_i;

  // Fetch lookup: zero-latency, reads pre-update contents (no bypass from training).
  always_comb begin
    hit_f_o            = 1'b0;
    pc_src_pred_f_o    = 1'b0;
    pred_pc_target_f_o = 32'h0000_0000;
    if (valid_r[idx_f_s] && (tag_r[idx_f_s] == tag_of(pc_f_i))) begin
      hit_f_o            = 1'b1;
      pc_src_pred_f_o    = ctr_r[idx_f_s][1];
      pred_pc_target_f_o = target_r[idx_f_s];
    end else begin
      hit_f_o = 1'b0;
    end
  end

  // Training decision for the single entry addressed by the execute PC.
  always_comb begin
    alloc_s    = 1'b0;
    ctr_we_s   = 1'b0;
    tgt_we_s   = 1'b0;
    ctr_next_s = ctr_r[idx_e_s];
    if (train_s) begin
      if (hit_e_s) begin
        ctr_we_s = 1'b1;
        if (pc_src_res_e_i) begin
          ctr_next_s = sat_inc(ctr_r[idx_e_s]);
          tgt_we_s   = 1'b1;
        end else begin
          ctr_next_s = sat_dec(ctr_r[idx_e_s]);
        end
      end else if (pc_src_res_e_i) begin
        alloc_s    = 1'b1;
        ctr_we_s   = 1'b1;
        tgt_we_s   = 1'b1;
        ctr_next_s = CTR_INIT;
      end else begin
        // Not-taken misses are never allocated.
        alloc_s = 1'b0;
      end
    end else begin
      ctr_we_s = 1'b0;
    end
  end

  // Valid bits and counters: async reset, invalidate wins over training.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_r <= {ENTRIES{1'b0}};
      for (int i = 0; i < int'(ENTRIES); i++) begin
        ctr_r[i] <= 2'b01;
      end
    end else begin
      if (invalidate_i) begin
        valid_r <= {ENTRIES{1'b0}};
      end else if (alloc_s) begin
        valid_r[idx_e_s] <= 1'b1;
      end else begin
        valid_r <= valid_r;
      end
      if (ctr_we_s) begin
        ctr_r[idx_e_s] <= ctr_next_s;
      end else begin
        ctr_r[idx_e_s] <= ctr_r[idx_e_s];
      end
    end
  end

  // Tag and target payload; meaningless while the valid bit is clear, so unreset.
  always_ff @(posedge clk_i) begin
    if (alloc_s) begin
      tag_r[idx_e_s] <= tag_e_s;
    end else begin
      tag_r[idx_e_s] <= tag_r[idx_e_s];
    end
    if (tgt_we_s) begin
      target_r[idx_e_s] <= pc_target_e_i;
    end else begin
      target_r[idx_e_s] <= target_r[idx_e_s];
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: expected lookups are queued when driven
// and popped for comparison once the combinational outputs settle.
module tb_branch_target_predictor;

  logic        clk;
  logic        reset_i;
  logic [31:0] pc_f_i;
  logic [31:0] pred_pc_target_f_o;
  logic        pc_src_pred_f_o;
  logic        hit_f_o;
  logic [31:0] pc_e_i;
  logic [31:0] pc_target_e_i;
  logic [1:0]  branch_op_e_i;
  logic        pc_src_res_e_i;
  logic        stall_e_i;
  logic        flush_e_i;
  logic        invalidate_i;

  typedef struct packed {
    logic        hit;
    logic        pred;
    logic [31:0] tgt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  branch_target_predictor dut (
    .clk_i              (clk),
    .reset_i            (reset_i),
    .pc_f_i             (pc_f_i),
    .pred_pc_target_f_o (pred_pc_target_f_o),
    .pc_src_pred_f_o    (pc_src_pred_f_o),
    .hit_f_o            (hit_f_o),
    .pc_e_i             (pc_e_i),
    .pc_target_e_i      (pc_target_e_i),
    .branch_op_e_i      (branch_op_e_i),
    .pc_src_res_e_i     (pc_src_res_e_i),
    .stall_e_i          (stall_e_i),
    .flush_e_i          (flush_e_i),
    .invalidate_i       (invalidate_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out();
    exp_t  e;
    exp_t  o;
    string n;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    o = {hit_f_o, pc_src_pred_f_o, pred_pc_target_f_o};
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed hit=%0b pred=%0b target=%h expected hit=%0b pred=%0b target=%h",
             n, o.hit, o.pred, o.tgt, e.hit, e.pred, e.tgt);
    end
  endtask

  // Look up without advancing to a new cycle (same-cycle observation).
  task automatic lookup_now(input string nm, input logic [31:0] pc,
                            input logic h, input logic p, input logic [31:0] t);
    pc_f_i = pc;
    exp_q.push_back({h, p, t});
    name_q.push_back(nm);
    #1;
    check_out();
  endtask

  task automatic lookup(input string nm, input logic [31:0] pc,
                        input logic h, input logic p, input logic [31:0] t);
    @(negedge clk);
    lookup_now(nm, pc, h, p, t);
  endtask

  task automatic train_drive(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] op,
                             input logic taken, input logic stall, input logic flush, input logic inv);
    @(negedge clk);
    pc_e_i         = pc;
    pc_target_e_i  = tgt;
    branch_op_e_i  = op;
    pc_src_res_e_i = taken;
    stall_e_i      = stall;
    flush_e_i      = flush;
    invalidate_i   = inv;
  endtask

  task automatic train_end();
    @(posedge clk);
    #1;
    branch_op_e_i  = 2'b00;
    pc_src_res_e_i = 1'b0;
    stall_e_i      = 1'b0;
    flush_e_i      = 1'b0;
    invalidate_i   = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
    train_drive(pc, tgt, 2'b01, taken, 1'b0, 1'b0, 1'b0);
    train_end();
  endtask

  initial begin
    reset_i        = 1'b0;
    pc_f_i         = 32'h0000_0000;
    pc_e_i         = 32'h0000_0000;
    pc_target_e_i  = 32'h0000_0000;
    branch_op_e_i  = 2'b00;
    pc_src_res_e_i = 1'b0;
    stall_e_i      = 1'b0;
    flush_e_i      = 1'b0;
    invalidate_i   = 1'b0;
    repeat (3) @(negedge clk);
    lookup_now("in_reset", 32'h100, 1'b0, 1'b0, 32'h0);
    reset_i = 1'b1;
    lookup("after_reset", 32'h100, 1'b0, 1'b0, 32'h0);

    // Allocation, aliasing and ignored low bits
    train(32'h100, 32'h200, 1'b1);
    lookup("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
    lookup("low_bits_ignored", 32'h101, 1'b1, 1'b1, 32'h200);
    lookup("upper_alias", 32'h0004_0100, 1'b1, 1'b1, 32'h200);
    lookup("other_idx_miss", 32'h104, 1'b0, 1'b0, 32'h0);

    // Counter saturation 10->11->11->11->10->01->00
    train(32'h100, 32'h204, 1'b1);
    lookup("ctr_11_a", 32'h100, 1'b1, 1'b1, 32'h204);
    train(32'h100, 32'h204, 1'b1);
    train(32'h100, 32'h204, 1'b1);
    lookup("ctr_11_sat", 32'h100, 1'b1, 1'b1, 32'h204);
    train(32'h100, 32'h999, 1'b0);
    lookup("ctr_10_tgt_kept", 32'h100, 1'b1, 1'b1, 32'h204);
    train(32'h100, 32'h999, 1'b0);
    lookup("ctr_01", 32'h100, 1'b1, 1'b0, 32'h204);
    train(32'h100, 32'h999, 1'b0);
    lookup("ctr_00", 32'h100, 1'b1, 1'b0, 32'h204);
    train(32'h100, 32'h999, 1'b0);
    train(32'h100, 32'h208, 1'b1);
    lookup("ctr_00_sat_then_01", 32'h100, 1'b1, 1'b0, 32'h208);

    // Suppressed training leaves ctr=01 and target untouched
    train_drive(32'h100, 32'h444, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    train_end();
    lookup("stall_no_train", 32'h100, 1'b1, 1'b0, 32'h208);
    train_drive(32'h100, 32'h444, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    train_end();
    lookup("flush_no_train", 32'h100, 1'b1, 1'b0, 32'h208);
    train_drive(32'h100, 32'h444, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    train_end();
    lookup("op00_no_train", 32'h100, 1'b1, 1'b0, 32'h208);
    train(32'h300, 32'h555, 1'b0);
    lookup("nt_miss_no_alloc", 32'h300, 1'b0, 1'b0, 32'h0);
    lookup("nt_miss_keeps_old", 32'h100, 1'b1, 1'b0, 32'h208);

    // Conflict replacement with same-cycle lookup seeing old contents
    train_drive(32'h200, 32'h600, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    lookup_now("same_cycle_new_miss", 32'h200, 1'b0, 1'b0, 32'h0);
    lookup_now("same_cycle_old_hit", 32'h100, 1'b1, 1'b0, 32'h208);
    train_end();
    lookup("replaced_hit", 32'h200, 1'b1, 1'b1, 32'h600);
    lookup("evicted_miss", 32'h100, 1'b0, 1'b0, 32'h0);

    // Invalidate beats a concurrent taken train
    train(32'h104, 32'h700, 1'b1);
    train(32'h108, 32'h800, 1'b1);
    train(32'h10c, 32'h900, 1'b1);
    lookup("pop_104", 32'h104, 1'b1, 1'b1, 32'h700);
    lookup("pop_10c", 32'h10c, 1'b1, 1'b1, 32'h900);
    train_drive(32'h110, 32'ha00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
    train_end();
    lookup("inv_200", 32'h200, 1'b0, 1'b0, 32'h0);
    lookup("inv_104", 32'h104, 1'b0, 1'b0, 32'h0);
    lookup("inv_108", 32'h108, 1'b0, 1'b0, 32'h0);
    lookup("inv_10c", 32'h10c, 1'b0, 1'b0, 32'h0);
    lookup("inv_train_dropped", 32'h110, 1'b0, 1'b0, 32'h0);

    // Async reset mid-stream
    train(32'h104, 32'hb00, 1'b1);
    lookup("realloc_104", 32'h104, 1'b1, 1'b1, 32'hb00);
    @(negedge clk);
    #2;
    reset_i = 1'b0;
    lookup_now("async_reset_now", 32'h104, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    reset_i = 1'b1;
    lookup_now("post_reset_miss", 32'h104, 1'b0, 1'b0, 32'h0);
    train(32'h104, 32'hc00, 1'b1);
    lookup("post_reset_alloc", 32'h104, 1'b1, 1'b1, 32'hc00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
